mu0_control: RTL and testbench

MU0_CONTROL -- requirements
Module: mu0_control

---
 rtl/mu0_control.sv | 141 ++++++++++++++
 tb/tb_mu0_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXECUTE/HALT sequencer decoding datapath selects,
// register enables and memory strobes from the current state and opcode.
module mu0_control (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output logic       Asel,
  output logic       Xsel,
  output logic       Ysel,
  output logic [1:0] M,
  output logic       ACCce,
  output logic       PCce,
  output logic       IRce,
  output logic       ACCoe,
  output logic       MEMrq,
  output logic       RnW,
  output logic       Halted
);

  localparam int unsigned OP_W = 4;
  localparam int unsigned M_W  = 2;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JGE = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JNE = OP_W'(6);
  localparam logic [OP_W-1:0] OP_STP = OP_W'(7);

  localparam logic [M_W-1:0] ALU_Y    = M_W'(0);
  localparam logic [M_W-1:0] ALU_ADD  = M_W'(1);
  localparam logic [M_W-1:0] ALU_INC  = M_W'(2);
  localparam logic [M_W-1:0] ALU_SUB  = M_W'(3);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   halted_q, halted_d;

  // State and halt flag; reset forces FETCH from any state, including HALT
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and combinational control decode
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    Asel     = 1'b0;
    Xsel     = 1'b0;
    Ysel     = 1'b0;
    M        = ALU_Y;
    ACCce    = 1'b0;
    PCce     = 1'b0;
    IRce     = 1'b0;
    ACCoe    = 1'b0;
    MEMrq    = 1'b0;
    RnW      = 1'b1;

    unique case (state_q)
      FETCH: begin
        // Read instruction at PC into IR while PC+1 is written back
        Asel    = 1'b0;
        MEMrq   = 1'b1;
        IRce    = 1'b1;
        Xsel    = 1'b1;
        M       = ALU_INC;
        PCce    = 1'b1;
        state_d = EXECUTE;
      end

      EXECUTE: begin
        state_d = FETCH;
        case (F)
          OP_LDA: begin
            Asel  = 1'b1;
            MEMrq = 1'b1;
            M     = ALU_Y;
            ACCce = 1'b1;
          end
          OP_STA: begin
            Asel  = 1'b1;
            MEMrq = 1'b1;
            RnW   = 1'b0;
            ACCoe = 1'b1;
          end
          OP_ADD: begin
            Asel  = 1'b1;
            MEMrq = 1'b1;
            ACCce = 1'b1;
            M     = ALU_ADD;
          end
          OP_SUB: begin
            Asel  = 1'b1;
            MEMrq = 1'b1;
            ACCce = 1'b1;
            M     = ALU_SUB;
          end
          OP_JMP: begin
            Ysel = 1'b1;
            PCce = 1'b1;
          end
          OP_JGE: begin
            Ysel = 1'b1;
            PCce = ~N;
          end
          OP_JNE: begin
            Ysel = 1'b1;
            PCce = ~Z;
          end
          OP_STP: begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase
  end

  assign Halted = halted_q;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: table of EXECUTE decode vectors plus
// hand sequences for reset, STP/HALT and recovery, compared via a scoreboard.
module tb_mu0_control;

  logic       Clk;
  logic       nReset;
  logic [3:0] F;
  logic       N;
  logic       Z;
  logic       Asel, Xsel, Ysel;
  logic [1:0] M;
  logic       ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted;

  mu0_control dut (
    .Clk    (Clk),
    .nReset (nReset),
    .F      (F),
    .N      (N),
    .Z      (Z),
    .Asel   (Asel),
    .Xsel   (Xsel),
    .Ysel   (Ysel),
    .M      (M),
    .ACCce  (ACCce),
    .PCce   (PCce),
    .IRce   (IRce),
    .ACCoe  (ACCoe),
    .MEMrq  (MEMrq),
    .RnW    (RnW),
    .Halted (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bit order: Asel Xsel Ysel M[1:0] ACCce PCce IRce ACCoe MEMrq RnW Halted
  localparam logic [11:0] EXP_FETCH = 12'b0_1_0_10_0_1_1_0_1_1_0;
  localparam logic [11:0] EXP_LDA   = 12'b1_0_0_00_1_0_0_0_1_1_0;
  localparam logic [11:0] EXP_STA   = 12'b1_0_0_00_0_0_0_1_1_0_0;
  localparam logic [11:0] EXP_ADD   = 12'b1_0_0_01_1_0_0_0_1_1_0;
  localparam logic [11:0] EXP_SUB   = 12'b1_0_0_11_1_0_0_0_1_1_0;
  localparam logic [11:0] EXP_JTAK  = 12'b0_0_1_00_0_1_0_0_0_1_0;
  localparam logic [11:0] EXP_JNOT  = 12'b0_0_1_00_0_0_0_0_0_1_0;
  localparam logic [11:0] EXP_NOP   = 12'b0_0_0_00_0_0_0_0_0_1_0;
  localparam logic [11:0] EXP_HALT  = 12'b0_0_0_00_0_0_0_0_0_1_1;

  typedef struct {
    string       name;
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input string nm, input logic [3:0] f,
                              input logic n, input logic z, input logic [11:0] e);
    vec_t v;
    v.name = nm; v.f = f; v.n = n; v.z = z; v.exp = e;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {Asel, Xsel, Ysel, M, ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted};
  endfunction

  task automatic pop_check();
    sb_t e;
    logic [11:0] act;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e   = sb.pop_front();
    act = outs();
    n_checks++;
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", e.name, act, e.exp);
    end
  endtask

  // One clock: advance, drive inputs, sample on the falling edge
  task automatic step(input string nm, input logic [3:0] f, input logic n,
                      input logic z, input logic [11:0] e);
    @(posedge Clk);
    #1;
    F = f; N = n; Z = z;
    sb.push_back('{nm, e});
    @(negedge Clk);
    pop_check();
  endtask

  task automatic check_now(input string nm, input logic [11:0] e);
    sb.push_back('{nm, e});
    #1;
    pop_check();
  endtask

  task automatic fetch_step(input string nm);
    step(nm, 4'($urandom), 1'($urandom), 1'($urandom), EXP_FETCH);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk("lda",      4'h0, 1'b0, 1'b0, EXP_LDA));
    vecs.push_back(mk("sta",      4'h1, 1'b1, 1'b1, EXP_STA));
    vecs.push_back(mk("add",      4'h2, 1'b0, 1'b1, EXP_ADD));
    vecs.push_back(mk("sub",      4'h3, 1'b1, 1'b0, EXP_SUB));
    vecs.push_back(mk("jmp",      4'h4, 1'b0, 1'b0, EXP_JTAK));
    vecs.push_back(mk("jmp_nz",   4'h4, 1'b1, 1'b1, EXP_JTAK));
    vecs.push_back(mk("jge_n1",   4'h5, 1'b1, 1'b0, EXP_JNOT));
    vecs.push_back(mk("jge_n0",   4'h5, 1'b0, 1'b1, EXP_JTAK));
    vecs.push_back(mk("jne_z1",   4'h6, 1'b0, 1'b1, EXP_JNOT));
    vecs.push_back(mk("jne_z0",   4'h6, 1'b1, 1'b0, EXP_JTAK));
    vecs.push_back(mk("nop_8",    4'h8, 1'b0, 1'b0, EXP_NOP));
    vecs.push_back(mk("nop_9",    4'h9, 1'b1, 1'b1, EXP_NOP));
    vecs.push_back(mk("nop_f",    4'hF, 1'b0, 1'b1, EXP_NOP));

    F = 4'h1; N = 1'b0; Z = 1'b0;
    nReset = 1'b0;
    #2;
    check_now("reset_fetch", EXP_FETCH);
    repeat (2) @(posedge Clk);
    check_now("reset_held", EXP_FETCH);
    @(negedge Clk);
    nReset = 1'b1;
    check_now("post_reset_fetch", EXP_FETCH);

    // Each instruction: EXECUTE cycle then back to FETCH
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].f, vecs[i].n, vecs[i].z, vecs[i].exp);
      fetch_step({vecs[i].name, "_next_fetch"});
    end

    // Asynchronous reset in the middle of a store
    step("sta_pre_reset", 4'h1, 1'b0, 1'b0, EXP_STA);
    #1;
    nReset = 1'b0;
    check_now("reset_mid_sta", EXP_FETCH);
    @(negedge Clk);
    nReset = 1'b1;
    check_now("reset_mid_sta_release", EXP_FETCH);
    step("lda_after_reset", 4'h0, 1'b0, 1'b0, EXP_LDA);
    fetch_step("lda_after_reset_fetch");

    // STP: Halted rises on the following edge and HALT is sticky
    step("stp_exec", 4'h7, 1'b0, 1'b0, EXP_NOP);
    for (int c = 0; c < 20; c++)
      step($sformatf("halt_cycle_%0d", c), 4'($urandom), 1'($urandom), 1'($urandom), EXP_HALT);

    #1;
    nReset = 1'b0;
    check_now("reset_from_halt", EXP_FETCH);
    @(negedge Clk);
    nReset = 1'b1;
    check_now("halt_release_fetch", EXP_FETCH);
    step("add_after_halt", 4'h2, 1'b0, 1'b0, EXP_ADD);
    fetch_step("add_after_halt_fetch");
    step("stp_again", 4'h7, 1'b1, 1'b1, EXP_NOP);
    step("halt_again", 4'h0, 1'b0, 1'b0, EXP_HALT);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
